// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor with saturating event counters, a run-length
// cycle counter with a programmable stop limit, and a registered read-back.
module pipe_perf_monitor #(
    parameter  int NUM_EVT = 2,
    parameter  int CNT_W   = 32,
    parameter  int CYC_W   = 32,
    localparam int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [CYC_W-1:0]   limit_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CYC_W-1:0]   cycle_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [NUM_EVT-1:0] ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt [NUM_EVT];
    logic [NUM_EVT-1:0] r_ovf;
    logic [CYC_W-1:0]   r_cycle;
    logic [CYC_W-1:0]   r_lim;
    logic [CNT_W-1:0]   r_rd_data;

    logic [CYC_W-1:0]   w_cyc_next;
    logic [CNT_W-1:0]   w_rd_mux;
    logic               w_busy;
    logic               w_done;
    logic               w_start_run;

    // Cycle count as it will be after this edge; sticks at all-ones.
    assign w_cyc_next  = (r_cycle == '1) ? r_cycle : r_cycle + CYC_W'(1);
    assign w_start_run = (r_state == S_IDLE) && start_i && !clear_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) w_state_nxt = S_RUN;
                S_RUN:  if ((r_lim != '0) && (w_cyc_next == r_lim)) w_state_nxt = S_DONE;
                S_DONE: w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Limit is captured only on the IDLE->RUN transition.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lim <= '0;
        end else if (w_start_run) begin
            r_lim <= limit_i;
        end
    end

    // Cycle counter advances on every RUN edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cycle <= '0;
        end else if (clear_i) begin
            r_cycle <= '0;
        end else if (r_state == S_RUN) begin
            r_cycle <= w_cyc_next;
        end
    end

    // Per-channel saturating event counters with sticky overflow flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned k = 0; k < NUM_EVT; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf <= '0;
        end else if (clear_i) begin
            for (int unsigned k = 0; k < NUM_EVT; k++) begin
                r_cnt[k] <= '0;
            end
            r_ovf <= '0;
        end else if (r_state == S_RUN) begin
            for (int unsigned k = 0; k < NUM_EVT; k++) begin
                if (evt_i[k]) begin
                    if (r_cnt[k] == '1) begin
                        r_ovf[k] <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Read-back select; out-of-range selects return zero.
    always_comb begin
        w_rd_mux = '0;
        for (int unsigned k = 0; k < NUM_EVT; k++) begin
            if (32'(rd_sel_i) == k) begin
                w_rd_mux = r_cnt[k];
            end
        end
    end

    // Registered read-back of the pre-edge counter value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data_o = r_rd_data;
    assign cycle_o   = r_cycle;
    assign busy_o    = w_busy;
    assign done_o    = w_done;
    assign ovf_o     = r_ovf;

endmodule
